ifft_cfg_sequencer: RTL and testbench

IFFT_CFG_SEQUENCER -- requirements
Module: ifft_cfg_sequencer

---
 rtl/ifft_cfg_sequencer.sv | 98 +++++++++
 tb/tb_ifft_cfg_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ifft_cfg_sequencer.sv
// ifft_cfg_sequencer: sends a config word to the IFFT core, then gates NFFT-sample frames through with tlast regenerated.
module ifft_cfg_sequencer #(
  parameter int         NFFT        = 16,
  parameter logic [7:0] DEF_SCALE   = 8'hAA,
  parameter logic       DEF_FWD_INV = 1'b0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] s_axis_data_tdata,
  input  logic        s_axis_data_tvalid,
  input  logic        s_axis_data_tlast,
  output logic        s_axis_data_tready,
  output logic [31:0] m_axis_data_tdata,
  output logic        m_axis_data_tvalid,
  output logic        m_axis_data_tlast,
  input  logic        m_axis_data_tready,
  output logic [15:0] m_axis_config_tdata,
  output logic        m_axis_config_tvalid,
  input  logic        m_axis_config_tready,
  input  logic [7:0]  cfg_scale,
  input  logic        cfg_fwd_inv,
  input  logic        cfg_update,
  output logic [15:0] frame_count,
  output logic        err_tlast_missing,
  output logic        err_tlast_unexpected,
  output logic        in_cfg
);
  localparam int CW = $clog2(NFFT);
  localparam logic [8:0] DEF_CFG = {DEF_SCALE, DEF_FWD_INV};
  typedef enum logic {CFG, DATA} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] frame_q, frame_d;
  logic pend_q, pend_d, em_q, eu_q, beat, last, apply;
  logic [8:0] next_q, next_d, active_q, active_d, cfg_in, cfg_new;
  // A new configuration only lands at a frame boundary or on a config handshake.
  always_comb begin
    cfg_in   = {cfg_scale, cfg_fwd_inv};
    beat     = state_q == DATA && s_axis_data_tvalid && m_axis_data_tready;
    last     = cnt_q == CW'(NFFT - 1);
    apply    = pend_q | cfg_update;
    cfg_new  = cfg_update ? cfg_in : next_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    pend_d   = pend_q | cfg_update;
    next_d   = cfg_update ? cfg_in : next_q;
    active_d = active_q;
    if (state_q == CFG && m_axis_config_tready) begin
      if (apply) begin
        active_d = cfg_new;
        pend_d   = 1'b0;
      end else begin
        state_d = DATA;
        cnt_d   = '0;
      end
    end else if (beat) begin
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      frame_d = last ? frame_q + 16'd1 : frame_q;
      if (last && apply) begin
        state_d  = CFG;
        active_d = cfg_new;
        pend_d   = 1'b0;
      end
    end
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= CFG;
      cnt_q    <= '0;
      frame_q  <= '0;
      pend_q   <= 1'b0;
      next_q   <= DEF_CFG;
      active_q <= DEF_CFG;
      em_q     <= 1'b0;
      eu_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      pend_q   <= pend_d;
      next_q   <= next_d;
      active_q <= active_d;
      em_q     <= beat & last & ~s_axis_data_tlast;
      eu_q     <= beat & ~last & s_axis_data_tlast;
    end
  end
  assign in_cfg               = state_q == CFG;
  assign m_axis_config_tvalid = in_cfg;
  assign m_axis_config_tdata  = {7'b0, active_q};
  assign s_axis_data_tready   = !in_cfg && m_axis_data_tready;
  assign m_axis_data_tvalid   = !in_cfg && s_axis_data_tvalid;
  assign m_axis_data_tdata    = s_axis_data_tdata;
  assign m_axis_data_tlast    = !in_cfg && last;
  assign frame_count          = frame_q;
  assign err_tlast_missing    = em_q;
  assign err_tlast_unexpected = eu_q;
endmodule

// File: tb/tb_ifft_cfg_sequencer.sv
// tb_ifft_cfg_sequencer: directed scenarios plus random traffic checked against a frame-level reference model.
module tb_ifft_cfg_sequencer;
  localparam int NFFT = 16;
  logic aclk = 0, areset = 1;
  logic [31:0] s_tdata = 0, m_tdata;
  logic s_tvalid = 0, s_tlast = 0, s_tready, m_tvalid, m_tlast, m_tready = 0;
  logic [15:0] c_tdata, frame_count;
  logic c_tvalid, c_tready = 0, cfg_fwd_inv = 0, cfg_update = 0;
  logic [7:0] cfg_scale = 0;
  logic err_m, err_u, in_cfg;
  int n_chk = 0, n_fail = 0;
  int m_cfg, m_cnt, m_pend, m_em, m_eu;
  logic [15:0] m_frames;
  logic [8:0] m_next, m_active;
  ifft_cfg_sequencer #(.NFFT(NFFT)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid), .s_axis_data_tlast(s_tlast),
    .s_axis_data_tready(s_tready),
    .m_axis_data_tdata(m_tdata), .m_axis_data_tvalid(m_tvalid), .m_axis_data_tlast(m_tlast),
    .m_axis_data_tready(m_tready),
    .m_axis_config_tdata(c_tdata), .m_axis_config_tvalid(c_tvalid), .m_axis_config_tready(c_tready),
    .cfg_scale(cfg_scale), .cfg_fwd_inv(cfg_fwd_inv), .cfg_update(cfg_update),
    .frame_count(frame_count), .err_tlast_missing(err_m), .err_tlast_unexpected(err_u), .in_cfg(in_cfg)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_cfg = 1; m_cnt = 0; m_frames = 0; m_pend = 0; m_em = 0; m_eu = 0;
    m_next = {8'hAA, 1'b0}; m_active = {8'hAA, 1'b0};
  endtask
  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic sv, input logic sl, input logic [31:0] sd, input logic mr,
                      input logic cr, input logic cu, input logic [7:0] cs, input logic cf, input logic rst);
    int beat, islast, apply;
    logic [8:0] newc;
    @(negedge aclk);
    s_tvalid = sv; s_tlast = sl; s_tdata = sd; m_tready = mr; c_tready = cr;
    cfg_update = cu; cfg_scale = cs; cfg_fwd_inv = cf; areset = rst;
    #1;
    chk("in_cfg", in_cfg, m_cfg);
    chk("cfg_tvalid", c_tvalid, m_cfg);
    chk("cfg_tdata", c_tdata, {7'b0, m_active});
    chk("s_tready", s_tready, !m_cfg && mr);
    chk("m_tvalid", m_tvalid, !m_cfg && sv);
    chk("m_tlast", m_tlast, !m_cfg && m_cnt == NFFT - 1);
    if (!m_cfg) chk("m_tdata", m_tdata, sd);
    chk("frame_count", frame_count, m_frames);
    chk("err_missing", err_m, m_em);
    chk("err_unexpected", err_u, m_eu);
    if (rst) model_reset();
    else begin
      beat = !m_cfg && sv && mr;
      islast = m_cnt == NFFT - 1;
      apply = m_pend || cu;
      newc = cu ? {cs, cf} : m_next;
      m_em = beat && islast && !sl;
      m_eu = beat && !islast && sl;
      if (cu) begin m_next = {cs, cf}; m_pend = 1; end
      if (m_cfg) begin
        if (cr) begin
          if (apply) begin m_active = newc; m_pend = 0; end
          else begin m_cfg = 0; m_cnt = 0; end
        end
      end else if (beat) begin
        if (islast) begin
          m_cnt = 0; m_frames++;
          if (apply) begin m_active = newc; m_pend = 0; m_cfg = 1; end
        end else m_cnt++;
      end
    end
  endtask
  task automatic post();
    @(posedge aclk); #1;
  endtask
  task automatic data_beat(input logic sl, input logic cu, input logic [7:0] cs, input logic cf);
    step(1, sl, $urandom, 1, 0, cu, cs, cf, 0);
  endtask
  initial begin
    int guard;
    repeat (3) @(posedge aclk);
    model_reset();
    step(0, 0, 0, 1, 1, 0, 0, 0, 1);
    // Reset word, then config handshake into DATA.
    post();
    chk("rst_word", c_tdata, 16'h0154);
    chk("rst_in_cfg", in_cfg, 1);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Clean frame.
    for (int i = 1; i <= NFFT; i++) data_beat(i == NFFT, 0, 0, 0);
    post();
    chk("frame1_count", frame_count, 1);
    chk("frame1_no_err", {err_m, err_u}, 0);
    // Downstream backpressure toggling.
    guard = 0;
    while (m_frames == 1 && guard < 100) begin
      step(1, m_cnt == NFFT - 1, $urandom, guard % 2, 0, 0, 0, 0, 0);
      guard++;
    end
    chk("toggle_done", m_frames, 2);
    // Config update mid-frame lands at the frame boundary.
    for (int i = 1; i <= NFFT; i++) data_beat(i == NFFT, i == 5, 8'h55, 1);
    post();
    chk("upd_in_cfg", in_cfg, 1);
    chk("upd_word", c_tdata, 16'h00AB);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    post();
    chk("upd_resume", in_cfg, 0);
    // Misplaced tlast.
    for (int i = 1; i <= NFFT; i++) begin
      data_beat(i == 8, 0, 0, 0);
      if (i == 8) begin post(); chk("unexp_pulse", err_u, 1); end
      if (i == NFFT) begin post(); chk("missing_pulse", err_m, 1); end
    end
    // Reset mid-frame.
    for (int i = 1; i <= 9; i++) data_beat(0, 0, 0, 0);
    step(1, 0, $urandom, 1, 0, 1, 8'h12, 1, 1);
    post();
    chk("rst_mid_count", frame_count, 0);
    chk("rst_mid_word", c_tdata, 16'h0154);
    chk("rst_mid_valid", m_tvalid, 0);
    step(1, 0, $urandom, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 4000; i++)
      step($urandom % 4 != 0, (m_cnt == NFFT - 1) ^ ($urandom % 12 == 0), $urandom, $urandom % 3 != 0,
           $urandom % 2, $urandom % 40 == 0, 8'($urandom), 1'($urandom), $urandom % 500 == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
